// File: rtl/uart_tx_queue_if.sv
// -----------------------------------------------------------------------------
// uart_tx_queue_if
//
// Bundles the signals between the transmit byte queue and its surroundings:
// the bus-side write port, the queue status, and the handshake with the
// MiniUART transmit unit.
//
//   wr_en, wr_data    write strobe and byte to enqueue
//   full, empty       queue status
//   count             occupancy (DEPTH_LOG2+1 bits)
//   en                drain enable
//   ts                transmit unit status, 1 = idle
//   d_out, load       byte and one-cycle load pulse to the transmit unit
//   ovf, ovf_clr      sticky overflow flag and its clear
//                     (present only when UART_TXQ_OVF_EN is defined)
//
// Modports: master = the side that writes bytes and reports ts,
//           slave  = the queue itself.
// DEPTH_LOG2 must match the parameter of the attached uart_tx_queue.
// -----------------------------------------------------------------------------
interface uart_tx_queue_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  wr_en;
    logic [7:0]            wr_data;
    logic                  full;
    logic                  empty;
    logic [DEPTH_LOG2:0]   count;
    logic                  en;
    logic                  ts;
    logic [7:0]            d_out;
    logic                  load;
`ifdef UART_TXQ_OVF_EN
    logic                  ovf;
    logic                  ovf_clr;

    modport master (
        output wr_en, wr_data, en, ts, ovf_clr,
        input  full, empty, count, d_out, load, ovf
    );

    modport slave (
        input  wr_en, wr_data, en, ts, ovf_clr,
        output full, empty, count, d_out, load, ovf
    );
`else
    modport master (
        output wr_en, wr_data, en, ts,
        input  full, empty, count, d_out, load
    );

    modport slave (
        input  wr_en, wr_data, en, ts,
        output full, empty, count, d_out, load
    );
`endif
endinterface

// File: rtl/uart_tx_queue.sv
// -----------------------------------------------------------------------------
// uart_tx_queue
//
// Byte queue and load sequencer in front of the MiniUART transmit unit.
// Bytes written on the bus side are stored in a circular FIFO; whenever the
// transmit unit reports idle (ts=1) and draining is enabled, one byte is
// popped, presented on d_out and announced with a single-cycle load pulse.
//
// Ports:
//   clk   system clock, all state updates on the rising edge
//   rst   asynchronous reset, active-low; empties the queue, FSM to IDLE
//   bus   uart_tx_queue_if.slave (write port, status, transmit handshake)
//
// Parameters:
//   DEPTH_LOG2  log2 of the queue depth, legal range 1..6
//
// Optional feature (macro UART_TXQ_OVF_EN):
//   defined   -> bus.ovf sticky overflow flag, set by a write while full,
//                cleared by bus.ovf_clr (set wins over clear)
//   undefined -> writes while full are dropped silently
// -----------------------------------------------------------------------------
module uart_tx_queue #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_queue_if.slave   bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] CNT_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Storage and bookkeeping
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wp_reg;
    logic [DEPTH_LOG2-1:0] rp_reg;
    logic [DEPTH_LOG2:0]   count_reg;
    logic [DEPTH_LOG2:0]   count_next;
    logic                  full_reg;
    logic                  empty_reg;

    // Sequencer
    state_t                state_reg;
    logic [7:0]            d_out_reg;
    logic                  load_reg;

    logic                  wr_accept;
    logic                  pop;

    // A write is judged against the status flags as they stand before this
    // edge, so a write while full is dropped even if a pop frees a slot on
    // the same edge.
    assign wr_accept = bus.wr_en && !full_reg;

    // The en/ts gate is only consulted from IDLE; a byte already handed to
    // LOAD or HOLD always runs to completion.
    assign pop = (state_reg == ST_IDLE) && bus.en && bus.ts && !empty_reg;

    always_comb begin
        count_next = count_reg;
        unique case ({wr_accept, pop})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    // Queue storage: plain array without reset so it maps onto RAM. Writes
    // are blocked while reset is held so the queue stays genuinely empty.
    always_ff @(posedge clk) begin
        if (rst && wr_accept) begin
            mem[wp_reg] <= bus.wr_data;
        end
    end

    // Pointers, occupancy and status flags. count is tracked on its own
    // rather than derived from the pointers, which alias when full.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_reg    <= '0;
            rp_reg    <= '0;
            count_reg <= '0;
            full_reg  <= 1'b0;
            empty_reg <= 1'b1;
        end else begin
            if (wr_accept) begin
                wp_reg <= wp_reg + 1'b1;
            end
            if (pop) begin
                rp_reg <= rp_reg + 1'b1;
            end
            count_reg <= count_next;
            full_reg  <= (count_next == DEPTH_CNT);
            empty_reg <= (count_next == '0);
        end
    end

    // Load sequencer. The byte is fetched from the array on the pop edge
    // (registered read) and held on d_out until the next pop.
    // HOLD covers the cycle after the load pulse: the transmit unit drops ts
    // only after sampling load, so IDLE must not look at ts straight away.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            d_out_reg <= 8'h00;
            load_reg  <= 1'b0;
        end else begin
            load_reg <= 1'b0;
            unique case (state_reg)
                ST_IDLE: begin
                    if (pop) begin
                        state_reg <= ST_LOAD;
                        d_out_reg <= mem[rp_reg];
                        load_reg  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    state_reg <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (bus.ts) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef UART_TXQ_OVF_EN
    logic ovf_reg;

    // Sticky overflow: a dropped write sets it; set wins over a same-cycle
    // clear so no overflow event is ever lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_reg <= 1'b0;
        end else if (bus.wr_en && full_reg) begin
            ovf_reg <= 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_reg <= 1'b0;
        end
    end

    assign bus.ovf = ovf_reg;
`endif

    assign bus.full  = full_reg;
    assign bus.empty = empty_reg;
    assign bus.count = count_reg;
    assign bus.d_out = d_out_reg;
    assign bus.load  = load_reg;

endmodule
